// File: rtl/effect_clipper.sv
// effect_clipper: pops one sample, applies a power-of-two pre-gain and a
// symmetric hard clip, then hands raw and clipped samples to the mixer.
`timescale 1ns/1ps
module effect_clipper #(
  parameter int data_width = 16,
  parameter int gain_shift = 2,
  parameter int clip_level = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic [data_width-1:0] i_data,
  input  logic                  i_read_ready,
  input  logic                  i_read_done,
  output logic                  o_dv,
  output logic [data_width-1:0] o_data_sw0,
  output logic [data_width-1:0] o_data_sw1,
  output logic                  o_clip_flag
);

  localparam int GW = data_width + gain_shift;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_GAIN    = 3'd3;
  localparam logic [2:0] S_CLIP    = 3'd4;
  localparam logic [2:0] S_HANDOFF = 3'd5;

  localparam logic signed [GW-1:0] CLIP_P = GW'(clip_level);
  localparam logic signed [GW-1:0] CLIP_N = -CLIP_P;

  logic [2:0]                  r_state;
  logic                        r_rd_en;
  logic signed [data_width-1:0] r_sample;
  logic signed [GW-1:0]        r_gain;
  logic                        r_dv;
  logic [data_width-1:0]       r_sw0;
  logic [data_width-1:0]       r_sw1;
  logic                        r_flag;

  logic signed [GW-1:0]        w_sext;
  logic signed [GW-1:0]        w_gain;
  logic [data_width-1:0]       w_sw1;
  logic                        w_flag;

  assign w_sext = GW'(r_sample);
  assign w_gain = w_sext <<< gain_shift;

  // Hard clip of the gained sample, compared at full gained width
  always_comb begin
    w_sw1  = r_gain[data_width-1:0];
    w_flag = 1'b0;
    if (r_gain > CLIP_P) begin
      w_sw1  = CLIP_P[data_width-1:0];
      w_flag = 1'b1;
    end else if (r_gain < CLIP_N) begin
      w_sw1  = CLIP_N[data_width-1:0];
      w_flag = 1'b1;
    end
  end

  // Sample sequencer: pop, capture, gain, clip, then hold for the mixer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rd_en  <= 1'b0;
      r_sample <= '0;
      r_gain   <= '0;
      r_dv     <= 1'b0;
      r_sw0    <= '0;
      r_sw1    <= '0;
      r_flag   <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_fifo_empty) begin
            r_state <= S_READ;
            r_rd_en <= 1'b1;
          end
        end
        S_READ: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_sample <= i_data;
          r_state  <= S_GAIN;
        end
        S_GAIN: begin
          r_gain  <= w_gain;
          r_state <= S_CLIP;
        end
        S_CLIP: begin
          r_sw0   <= r_sample;
          r_sw1   <= w_sw1;
          r_flag  <= w_flag;
          r_state <= S_HANDOFF;
        end
        S_HANDOFF: begin
          if (r_dv) begin
            if (i_read_done) begin
              r_dv    <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (i_read_ready) begin
            r_dv <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_dv    <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_rd_en = r_rd_en;
  assign o_dv         = r_dv;
  assign o_data_sw0   = r_sw0;
  assign o_data_sw1   = r_sw1;
  assign o_clip_flag  = r_flag;

endmodule

// File: tb/tb_effect_clipper.sv
// tb_effect_clipper: directed vectors through a FIFO model, scoreboard
// monitor on the mixer handshake.
`timescale 1ns/1ps
module tb_effect_clipper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_fifo_empty = 1'b1;
  logic        i_read_ready = 1'b0;
  logic        i_read_done = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_fifo_rd_en;
  logic        o_dv;
  logic [15:0] o_data_sw0;
  logic [15:0] o_data_sw1;
  logic        o_clip_flag;

  effect_clipper dut (
    .clk          (clk),
    .reset        (reset),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd_en (o_fifo_rd_en),
    .i_data       (i_data),
    .i_read_ready (i_read_ready),
    .i_read_done  (i_read_done),
    .o_dv         (o_dv),
    .o_data_sw0   (o_data_sw0),
    .o_data_sw1   (o_data_sw1),
    .o_clip_flag  (o_clip_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s0;
    int s1;
    int f;
  } exp_t;

  int   n_chk = 0;
  int   n_pass = 0;
  logic [15:0] fifo_q[$];
  exp_t exp_q[$];
  int   pop_cnt = 0;
  int   cyc = 0;
  int   last_pop = -100;
  int   dv_seen = 0;
  int   dv_len = 0;
  bit   auto_done = 1'b1;
  bit   manual_done = 1'b0;
  logic prev_dv = 1'b0;
  logic [15:0] prev0 = '0;
  logic [15:0] prev1 = '0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  // FIFO model: pops on the strobe, data held until the next pop
  always @(negedge clk) begin
    cyc++;
    if (o_fifo_rd_en) begin
      pop_cnt++;
      chk("pop_gap_ge7", int'(cyc - last_pop >= 7), 1);
      last_pop = cyc;
      chk("pop_nonempty", int'(fifo_q.size() > 0), 1);
      if (fifo_q.size() > 0) i_data = fifo_q.pop_front();
    end
    i_fifo_empty = (fifo_q.size() == 0);
  end

  // Mixer model and scoreboard monitor
  always @(negedge clk) begin
    if (o_dv) begin
      if (!prev_dv) begin
        chk("dv_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sw0", int'($signed(o_data_sw0)), e.s0);
          chk("sw1", int'($signed(o_data_sw1)), e.s1);
          chk("clip_flag", int'(o_clip_flag), e.f);
        end
      end else begin
        chk("sw0_stable", int'(o_data_sw0), int'(prev0));
        chk("sw1_stable", int'(o_data_sw1), int'(prev1));
      end
      dv_seen++;
    end else begin
      if (dv_seen > 0) dv_len = dv_seen;
      dv_seen = 0;
    end
    prev_dv = o_dv;
    prev0 = o_data_sw0;
    prev1 = o_data_sw1;
    i_read_done = (auto_done && dv_seen == 2) || manual_done;
  end

  task automatic push(input int s, input int e1, input int ef);
    exp_t e;
    e.s0 = s;
    e.s1 = e1;
    e.f = ef;
    fifo_q.push_back(16'(s));
    exp_q.push_back(e);
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((exp_q.size() > 0 || o_dv || fifo_q.size() > 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(nm, int'(t < 400), 1);
  endtask

  initial begin
    int rd_hi;
    int dv_hi;
    int pc0;
    int t;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", int'(o_fifo_rd_en), 0);
    chk("rst_dv", int'(o_dv), 0);
    chk("rst_sw0", int'(o_data_sw0), 0);
    chk("rst_sw1", int'(o_data_sw1), 0);
    chk("rst_flag", int'(o_clip_flag), 0);
    reset = 1'b0;

    rd_hi = 0;
    dv_hi = 0;
    repeat (50) begin
      @(negedge clk);
      rd_hi += int'(o_fifo_rd_en);
      dv_hi += int'(o_dv);
    end
    chk("idle_rd_en", rd_hi, 0);
    chk("idle_dv", dv_hi, 0);
    chk("idle_sw1", int'(o_data_sw1), 0);

    i_read_ready = 1'b1;
    push(1000, 4000, 0);
    push(3000, 8192, 1);
    push(-32768, -8192, 1);
    push(2048, 8192, 0);
    push(2049, 8192, 1);
    push(-2048, -8192, 0);
    push(-2049, -8192, 1);
    push(-1, -4, 0);
    push(32767, 8192, 1);
    drain("vec_timeout");
    chk("vec_pops", pop_cnt, 9);
    chk("dv_len", dv_len, 2);

    i_read_ready = 1'b0;
    pc0 = pop_cnt;
    push(1234, 4936, 0);
    push(500, 2000, 0);
    repeat (6) @(negedge clk);
    dv_hi = 0;
    repeat (8) begin
      @(negedge clk);
      dv_hi += int'(o_dv);
    end
    manual_done = 1'b1;
    repeat (2) @(negedge clk);
    manual_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      dv_hi += int'(o_dv);
    end
    chk("stall_dv", dv_hi, 0);
    chk("stall_pops", pop_cnt, pc0 + 1);
    chk("stall_sw0", int'($signed(o_data_sw0)), 1234);
    chk("stall_sw1", int'($signed(o_data_sw1)), 4936);
    i_read_ready = 1'b1;
    @(negedge clk);
    chk("ready_dv_rise", int'(o_dv), 1);
    drain("stall_timeout");
    chk("stall_pops_end", pop_cnt, pc0 + 2);

    auto_done = 1'b0;
    push(700, 2800, 0);
    t = 0;
    while (!o_dv && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("rst_hold_dv_seen", int'(o_dv), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_hs_dv", int'(o_dv), 0);
    chk("rst_hs_rd_en", int'(o_fifo_rd_en), 0);
    chk("rst_hs_sw0", int'(o_data_sw0), 0);
    chk("rst_hs_flag", int'(o_clip_flag), 0);
    reset = 1'b0;
    auto_done = 1'b1;
    push(100, 400, 0);
    drain("fresh_timeout");

    fifo_q.push_back(16'd5555);
    t = 0;
    while (!o_fifo_rd_en && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("read_seen", int'(o_fifo_rd_en), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dv_hi = 0;
    repeat (15) begin
      @(negedge clk);
      dv_hi += int'(o_dv);
    end
    chk("discard_dv", dv_hi, 0);
    push(-300, -1200, 0);
    drain("post_discard_timeout");
    chk("exp_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
